pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
Parametrised chain of pipeline bus registers, the successor to the fixed IF/ID, ID/EXE, EXE/MEM and MEM/WB bus registers. It provides N stages of WIDTH-bit payload with a valid/ready handshake and bubble collapsing. Per-stage flush supports jump/exception squash. It sits between any two pipeline units and replaces the hand-written `*_BUS_REG` registers in the CPU top.

Parameters:
- STAGES, 4, number of register stages; legal range 1 to 16.
- WIDTH, 64, payload width in bits.
- OCC_W, $clog2(STAGES+2), width of the occupancy output (covers the skid entry).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream item present
- in_ready  out  1  chain accepts the item this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  oldest item available downstream
- out_ready  in  1  downstream accepts the item
- out_data  out  WIDTH  payload of stage STAGES-1
- flush  in  STAGES  bit i squashes the item held in stage i
- occupancy  out  OCC_W  registered count of valid entries

Behaviour:
- Reset (async, active-high):
  - All stage valid bits and the skid valid bit clear immediately.
  - out_valid=0, occupancy=0.
  - in_ready=1 as soon as reset deasserts.
  - Payload registers are not reset; out_data is don't-care while out_valid=0.
  - Reset mid-transfer drops all items and no handshake completes.
- Stage state: valid[i] and data[i] for i = 0..STAGES-1. Stage 0 is the youngest; stage STAGES-1 is the oldest.
- Ready chain:
  - ready[STAGES] = out_ready.
  - ready[i] = !valid[i] | flush[i] | ready[i+1]. This path is combinational through all stages.
- Ports:
  - in_ready = ready[0].
  - out_valid = valid[STAGES-1] & !flush[STAGES-1].
  - out_data = data[STAGES-1].
- Advance: stage i loads from stage i-1 (stage 0 loads from the input) when ready[i]=1.
- Next valid:
  - valid[i] <= (i==0 ? in_valid : valid[i-1] & !flush[i-1]) whenever ready[i]=1.
  - Otherwise valid[i] <= valid[i] & !flush[i].
- Flush:
  - flush[i] invalidates the item currently in stage i. That item is neither forwarded nor retained.
  - An item entering stage i in the same cycle is kept.
- Bubble collapsing: an empty stage always accepts, even when downstream is stalled. Gaps close up under backpressure.
- Latency: an item accepted at edge k is visible on out_* after edge k+STAGES-1, i.e. STAGES cycles from the input handshake, given no stall.
- Throughput: 1 item/cycle with out_ready held at 1.
- Ordering: strict FIFO. No reordering or duplication under any combination of stall and flush.
- Occupancy: occupancy <= popcount of the next-state valid bits (plus the skid entry when enabled). Range is 0..STAGES (0..STAGES+1 with skid).
- Boundary cases:
  - Full chain with out_ready=0 gives in_ready=0.
  - Full chain with out_ready=1 accepts and emits in the same cycle.
  - flush all-ones with in_valid=1 leaves only the new item in stage 0.

Optional Feature:
- Macro: PIPE_SKID_EN.
- Defined:
  - A one-entry skid buffer sits on the input, and in_ready becomes registered: in_ready = !skid_valid.
  - The skid captures the input when the item is accepted but stage 0 is not ready.
  - The skid drains into stage 0 before new input is taken.
  - flush[0] also clears the skid.
  - Adds one entry of capacity and no extra latency when the skid is empty.
- Undefined: the combinational ready chain described above, with no skid.

Decomposition:
- Shared package pipe_pkg:
  - MAX_STAGES=16 constant.
  - Occupancy-width function.
  - Typedefs for the existing bus widths (IF_ID=62, ID_EXE=184, EXE_MEM=80, MEM_WB=43) so tops instantiate with named widths.
- One natural sub-module, pipe_stage: a single valid+data register with its ready/flush logic, instantiated STAGES times in a generate loop.
- The skid logic stays in the parent.

Test Plan (STAGES=4, WIDTH=8):
1. Assert reset while 3 items are in flight → out_valid=0 and occupancy=0 asynchronously; in_ready=1 after deassert; none of the 3 items ever appears.
2. Stream 0x01..0x10 with out_ready=1 → first out_valid 4 cycles after the first accept; one item per cycle in order; occupancy settles at 4.
3. out_ready=0, push 0x01..0x06 → exactly 4 accepted, in_ready=0, occupancy=4; raise out_ready → 0x01..0x06 emerge in order with no loss.
4. out_ready=0, push 0xA0, idle 2 cycles, push 0xB0 → bubble collapses; 0xA0 in stage 3, 0xB0 in stage 2; occupancy=2.
5. Stages hold 0xD(3), 0xC(2), 0xB(1), 0xA(0) with out_ready=0; pulse flush=4'b0011 → occupancy=2; on release only 0xD then 0xC emerge.
6. With PIPE_SKID_EN, full chain, drop out_ready while in_valid=1 → one extra item (5 total) accepted; in_ready falls a cycle later; all 5 items drain in order.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared limits, occupancy width helper and named bus widths for register chains
package pipe_pkg;

   localparam int MAX_STAGES = 16;

   localparam int IF_ID_W   = 62;
   localparam int ID_EXE_W  = 184;
   localparam int EXE_MEM_W = 80;
   localparam int MEM_WB_W  = 43;

   typedef logic [IF_ID_W-1:0]   if_id_bus_t;
   typedef logic [ID_EXE_W-1:0]  id_exe_bus_t;
   typedef logic [EXE_MEM_W-1:0] exe_mem_bus_t;
   typedef logic [MEM_WB_W-1:0]  mem_wb_bus_t;

   // Two extra codes: a full chain plus the optional skid entry.
   function automatic int occ_width(input int stages);
      return $clog2(stages + 2);
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid+payload slot of the register chain with its load/flush next-state logic
module pipe_stage #(
   parameter int WIDTH = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             flush_i,
   input  logic             ready_i,
   output logic             valid_o,
   output logic             valid_d_o,
   output logic             fwd_valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;

   // in_valid_i is already masked by the upstream stage's flush, so a squashed
   // item never lands here while an item entering this cycle survives flush_i.
   always_comb begin
      valid_d = valid_q & !flush_i;
      data_d  = data_q;
      if (ready_i) begin
         valid_d = in_valid_i;
         data_d  = in_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) valid_q <= 1'b0;
      else       valid_q <= valid_d;
   end

   always_ff @(posedge clk_i) begin
      data_q <= data_d;
   end

   assign valid_o     = valid_q;
   assign valid_d_o   = valid_d;
   assign fwd_valid_o = valid_q & !flush_i;
   assign data_o      = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - N-stage valid/ready register chain with bubble collapsing and flush; PIPE_SKID_EN adds an input skid entry
module pipe_reg_chain
   import pipe_pkg::*;
#(
   parameter int STAGES = 4,
   parameter int WIDTH  = 64,
   parameter int OCC_W  = occ_width(STAGES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   input  logic [STAGES-1:0] flush,
   output logic [OCC_W-1:0]  occupancy
);

   logic [STAGES:0]            ready;
   logic [STAGES-1:0]          stage_valid;
   logic [STAGES-1:0]          stage_valid_d;
   logic [STAGES:0]            link_valid;
   logic [STAGES:0][WIDTH-1:0] link_data;
   logic                       src_valid;
   logic [WIDTH-1:0]           src_data;
   logic                       skid_count;
   logic [OCC_W-1:0]           occ_q, occ_d;

   // Empty or flushed slots always accept, which is what closes bubbles under backpressure.
   always_comb begin
      ready[STAGES] = out_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         ready[i] = !stage_valid[i] | flush[i] | ready[i+1];
      end
   end

   assign link_valid[0] = src_valid;
   assign link_data[0]  = src_data;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      pipe_stage #(
         .WIDTH(WIDTH)
      ) u_stage (
         .clk_i      (clk),
         .rst_i      (reset),
         .in_valid_i (link_valid[i]),
         .in_data_i  (link_data[i]),
         .flush_i    (flush[i]),
         .ready_i    (ready[i]),
         .valid_o    (stage_valid[i]),
         .valid_d_o  (stage_valid_d[i]),
         .fwd_valid_o(link_valid[i+1]),
         .data_o     (link_data[i+1])
      );
   end

`ifdef PIPE_SKID_EN
   logic             skid_valid_q, skid_valid_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;

   assign in_ready   = !skid_valid_q;
   assign skid_count = skid_valid_d;

   // A held skid item is older than any new input, so it feeds stage 0 first.
   always_comb begin
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      src_valid    = in_valid;
      src_data     = in_data;
      if (skid_valid_q) begin
         src_valid = !flush[0];
         src_data  = skid_data_q;
         if (ready[0]) skid_valid_d = 1'b0;
      end else if (in_valid && !ready[0]) begin
         skid_valid_d = 1'b1;
         skid_data_d  = in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) skid_valid_q <= 1'b0;
      else       skid_valid_q <= skid_valid_d;
   end

   always_ff @(posedge clk) begin
      skid_data_q <= skid_data_d;
   end
`else
   assign in_ready   = ready[0];
   assign src_valid  = in_valid;
   assign src_data   = in_data;
   assign skid_count = 1'b0;
`endif

   always_comb begin
      occ_d = OCC_W'(skid_count);
      for (int i = 0; i < STAGES; i++) begin
         occ_d = occ_d + OCC_W'(stage_valid_d[i]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) occ_q <= '0;
      else       occ_q <= occ_d;
   end

   assign occupancy = occ_q;
   assign out_valid = link_valid[STAGES];
   assign out_data  = link_data[STAGES];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - self-checking bench for pipe_reg_chain at STAGES=4, WIDTH=8
module tb_pipe_reg_chain;

   localparam int STAGES = 4;
   localparam int WIDTH  = 8;
   localparam int OCC_W  = $clog2(STAGES + 2);
`ifdef PIPE_SKID_EN
   localparam int CAP = STAGES + 1;
`else
   localparam int CAP = STAGES;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_data;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_data;
   logic [STAGES-1:0] flush;
   logic [OCC_W-1:0]  occupancy;

   pipe_reg_chain #(
      .STAGES(STAGES),
      .WIDTH (WIDTH),
      .OCC_W (OCC_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .flush    (flush),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: items that have entered the chain and not yet left, oldest first.
   logic [WIDTH-1:0] sb_q[$];
   int   accepted, emitted;
   logic last_acc, last_emit, last_ir;
   int   last_occ;

   typedef struct {
      logic             iv;
      logic [WIDTH-1:0] din;
      logic             orr;
      logic [3:0]       fl;
      logic             exp_ir;
      logic             exp_ov;
      logic [WIDTH-1:0] exp_od;
      logic [2:0]       exp_occ;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic iv, input logic [7:0] din, input logic orr,
                              input logic [3:0] fl, input logic ir, input logic ov,
                              input logic [7:0] od, input logic [2:0] occ);
      vec_t r;
      r.iv = iv; r.din = din; r.orr = orr; r.fl = fl;
      r.exp_ir = ir; r.exp_ov = ov; r.exp_od = od; r.exp_occ = occ;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic orr);
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      out_ready = orr;
      flush     = '0;
      #1;
      last_ir   = in_ready;
      last_occ  = int'(occupancy);
      last_acc  = in_valid & in_ready;
      last_emit = out_valid & out_ready;
      check("occupancy", 32'(occupancy), 32'(sb_q.size()));
`ifndef PIPE_SKID_EN
      check("in_ready", 32'(in_ready), 32'((sb_q.size() < STAGES) || orr));
`endif
      if (last_emit) begin
         emitted++;
         if (sb_q.size() == 0) check("spurious_output", 32'(out_data), 32'hFFFF_FFFF);
         else                  check("out_data_order", 32'(out_data), 32'(sb_q.pop_front()));
      end
      if (last_acc) begin
         sb_q.push_back(d);
         accepted++;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int first_acc, first_emit, max_occ;
      logic [WIDTH-1:0] nxt;

      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("reset_in_ready", 32'(in_ready), 1);
      check("reset_out_valid", 32'(out_valid), 0);
      check("reset_occupancy", 32'(occupancy), 0);

`ifndef PIPE_SKID_EN
      // Fill/stall, partial flush, bubble collapse, full accept+emit, flush-all with input.
      vecs.push_back(v(1, 8'h0D, 0, 4'b0000, 1, 0, 8'h00, 0));
      vecs.push_back(v(1, 8'h0C, 0, 4'b0000, 1, 0, 8'h00, 1));
      vecs.push_back(v(1, 8'h0B, 0, 4'b0000, 1, 0, 8'h00, 2));
      vecs.push_back(v(1, 8'h0A, 0, 4'b0000, 1, 0, 8'h00, 3));
      vecs.push_back(v(0, 8'h00, 0, 4'b0000, 0, 1, 8'h0D, 4));
      vecs.push_back(v(0, 8'h00, 0, 4'b0011, 1, 1, 8'h0D, 4));
      vecs.push_back(v(0, 8'h00, 0, 4'b0000, 1, 1, 8'h0D, 2));
      vecs.push_back(v(0, 8'h00, 1, 4'b0000, 1, 1, 8'h0D, 2));
      vecs.push_back(v(0, 8'h00, 1, 4'b0000, 1, 1, 8'h0C, 1));
      vecs.push_back(v(0, 8'h00, 1, 4'b0000, 1, 0, 8'h00, 0));
      vecs.push_back(v(1, 8'hA0, 0, 4'b0000, 1, 0, 8'h00, 0));
      vecs.push_back(v(0, 8'h00, 0, 4'b0000, 1, 0, 8'h00, 1));
      vecs.push_back(v(0, 8'h00, 0, 4'b0000, 1, 0, 8'h00, 1));
      vecs.push_back(v(1, 8'hB0, 0, 4'b0000, 1, 0, 8'h00, 1));
      vecs.push_back(v(0, 8'h00, 0, 4'b0000, 1, 1, 8'hA0, 2));
      vecs.push_back(v(0, 8'h00, 0, 4'b0000, 1, 1, 8'hA0, 2));
      vecs.push_back(v(0, 8'h00, 0, 4'b0000, 1, 1, 8'hA0, 2));
      vecs.push_back(v(0, 8'h00, 1, 4'b0000, 1, 1, 8'hA0, 2));
      vecs.push_back(v(0, 8'h00, 1, 4'b0000, 1, 1, 8'hB0, 1));
      vecs.push_back(v(0, 8'h00, 1, 4'b0000, 1, 0, 8'h00, 0));
      vecs.push_back(v(1, 8'h11, 0, 4'b0000, 1, 0, 8'h00, 0));
      vecs.push_back(v(1, 8'h12, 0, 4'b0000, 1, 0, 8'h00, 1));
      vecs.push_back(v(1, 8'h13, 0, 4'b0000, 1, 0, 8'h00, 2));
      vecs.push_back(v(1, 8'h14, 0, 4'b0000, 1, 0, 8'h00, 3));
      vecs.push_back(v(1, 8'h15, 0, 4'b0000, 0, 1, 8'h11, 4));
      vecs.push_back(v(1, 8'h15, 1, 4'b0000, 1, 1, 8'h11, 4));
      vecs.push_back(v(0, 8'h00, 1, 4'b0000, 1, 1, 8'h12, 4));
      vecs.push_back(v(1, 8'h16, 0, 4'b1111, 1, 0, 8'h00, 3));
      vecs.push_back(v(0, 8'h00, 0, 4'b0000, 1, 0, 8'h00, 1));
      vecs.push_back(v(0, 8'h00, 1, 4'b0000, 1, 0, 8'h00, 1));
      vecs.push_back(v(0, 8'h00, 1, 4'b0000, 1, 0, 8'h00, 1));
      vecs.push_back(v(0, 8'h00, 1, 4'b0000, 1, 1, 8'h16, 1));
      vecs.push_back(v(0, 8'h00, 1, 4'b0000, 1, 0, 8'h00, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         in_valid  = vecs[i].iv;
         in_data   = vecs[i].din;
         out_ready = vecs[i].orr;
         flush     = vecs[i].fl;
         #1;
         check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
         check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
         if (vecs[i].exp_ov)
            check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_od));
         check($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].exp_occ));
      end
`endif

      // Streaming at full rate: latency and in-order delivery.
      accepted = 0; emitted = 0; first_acc = -1; first_emit = -1; max_occ = 0;
      for (int i = 0; i < 24; i++) begin
         drive(i < 16, WIDTH'(i + 1), 1'b1);
         if (last_acc && first_acc < 0)   first_acc = i;
         if (last_emit && first_emit < 0) first_emit = i;
         if (last_occ > max_occ)          max_occ = last_occ;
      end
      check("stream_latency", 32'(first_emit - first_acc), STAGES);
      check("stream_emitted", 32'(emitted), 16);
      check("stream_max_occupancy", 32'(max_occ), STAGES);

      // Backpressure from empty: capacity, in_ready low, then lossless drain.
      accepted = 0; emitted = 0; nxt = 8'h01;
      for (int i = 0; i < CAP + 4; i++) begin
         drive(1'b1, nxt, 1'b0);
         if (last_acc) nxt++;
      end
      check("stall_accepted", 32'(accepted), CAP);
      check("stall_in_ready", 32'(last_ir), 0);
      check("stall_occupancy", 32'(last_occ), CAP);
      for (int i = 0; i < 40; i++) begin
         if (sb_q.size() == 0 && nxt > 8'h06) break;
         drive(nxt <= 8'h06, nxt, 1'b1);
         if (last_acc) nxt++;
      end
      check("stall_drain_emitted", 32'(emitted), 6);
      check("stall_drain_empty", 32'(sb_q.size()), 0);

      // Reset with three items in flight: all of them are dropped.
      for (int i = 0; i < 3; i++) drive(1'b1, WIDTH'(8'h70 + i), 1'b0);
      drive(1'b0, '0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("pre_reset_out_valid", 32'(out_valid), 1);
      reset = 1'b1;
      #1;
      check("async_reset_out_valid", 32'(out_valid), 0);
      check("async_reset_occupancy", 32'(occupancy), 0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("post_reset_in_ready", 32'(in_ready), 1);
      sb_q.delete();
      for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b1);

      // Random traffic against the scoreboard.
      accepted = 0; emitted = 0;
      for (int i = 0; i < 300; i++) begin
         drive(($urandom % 4) != 0, WIDTH'($urandom), ($urandom % 3) != 0);
      end
      for (int i = 0; i < 40; i++) begin
         if (sb_q.size() == 0) break;
         drive(1'b0, '0, 1'b1);
      end
      check("random_drain_empty", 32'(sb_q.size()), 0);
      check("random_conservation", 32'(accepted), 32'(emitted));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
